// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer for the STFT CNN: READ, CONV1-3, FCL1-2 with a one-cycle gap per layer.
// Optional macro SEQ_STALL_EN lets iSTALL hold the RUN phase.
module cnn_layer_sequencer #(
    parameter int READ_LEN  = 1024,
    parameter int CONV1_LEN = 1008,
    parameter int CONV2_LEN = 1008,
    parameter int CONV3_LEN = 1008,
    parameter int FCL1_LEN  = 672,
    parameter int FCL2_LEN  = 12,
    parameter int CNT_WL    = 11
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iSTART,
    input  logic              iSTALL,
    output logic [2:0]        oSTATE,
    output logic              oEN,
    output logic              oMEM_SEL,
    output logic [CNT_WL-1:0] oCNT,
    output logic              oLAYER_DONE,
    output logic              oDONE,
    output logic              oBUSY
);

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_RUN,
        PH_GAP
    } phase_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_CONV1 = 3'd2;
    localparam logic [2:0] ST_CONV2 = 3'd3;
    localparam logic [2:0] ST_CONV3 = 3'd4;
    localparam logic [2:0] ST_FCL1  = 3'd5;
    localparam logic [2:0] ST_FCL2  = 3'd6;

    phase_t            r_phase;
    phase_t            w_phase_nxt;
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_en;
    logic              w_en_nxt;
    logic              r_mem_sel;
    logic              w_mem_sel_nxt;
    logic [CNT_WL-1:0] r_cnt;
    logic [CNT_WL-1:0] w_cnt_nxt;
    logic              r_layer_done;
    logic              w_layer_done_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic [CNT_WL-1:0] w_last;
    logic              w_stall;

`ifdef SEQ_STALL_EN
    assign w_stall = iSTALL;
`else
    logic w_unused_stall;
    assign w_stall        = 1'b0;
    assign w_unused_stall = iSTALL;
`endif

    always_comb begin
        w_last = '0;
        case (r_state)
            ST_READ:  w_last = CNT_WL'(READ_LEN - 1);
            ST_CONV1: w_last = CNT_WL'(CONV1_LEN - 1);
            ST_CONV2: w_last = CNT_WL'(CONV2_LEN - 1);
            ST_CONV3: w_last = CNT_WL'(CONV3_LEN - 1);
            ST_FCL1:  w_last = CNT_WL'(FCL1_LEN - 1);
            ST_FCL2:  w_last = CNT_WL'(FCL2_LEN - 1);
            default:  w_last = '0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_phase      <= PH_IDLE;
            r_state      <= ST_IDLE;
            r_en         <= 1'b0;
            r_mem_sel    <= 1'b0;
            r_cnt        <= '0;
            r_layer_done <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_state      <= w_state_nxt;
            r_en         <= w_en_nxt;
            r_mem_sel    <= w_mem_sel_nxt;
            r_cnt        <= w_cnt_nxt;
            r_layer_done <= w_layer_done_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_phase_nxt      = r_phase;
        w_state_nxt      = r_state;
        w_en_nxt         = 1'b0;
        w_mem_sel_nxt    = r_mem_sel;
        w_cnt_nxt        = r_cnt;
        w_layer_done_nxt = 1'b0;
        w_done_nxt       = 1'b0;
        w_busy_nxt       = r_busy;
        unique case (r_phase)
            PH_IDLE: begin
                if (iSTART) begin
                    w_phase_nxt   = PH_RUN;
                    w_state_nxt   = ST_READ;
                    w_en_nxt      = 1'b1;
                    w_cnt_nxt     = '0;
                    w_mem_sel_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            PH_RUN: begin
                if (r_en && (r_cnt == w_last)) begin
                    w_phase_nxt      = PH_GAP;
                    w_cnt_nxt        = '0;
                    w_layer_done_nxt = 1'b1;
                    w_done_nxt       = (r_state == ST_FCL2);
                end else begin
                    // a stalled cycle consumes nothing, so the count only moves after an enabled one
                    if (r_en) begin
                        w_cnt_nxt = r_cnt + CNT_WL'(1);
                    end
                    w_en_nxt = !w_stall;
                end
            end
            PH_GAP: begin
                w_cnt_nxt = '0;
                if (r_state == ST_FCL2) begin
                    w_phase_nxt   = PH_IDLE;
                    w_state_nxt   = ST_IDLE;
                    w_mem_sel_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                end else begin
                    w_phase_nxt = PH_RUN;
                    w_state_nxt = r_state + 3'd1;
                    w_en_nxt    = 1'b1;
                    // READ fills MEM0 and CONV1 reads it back, so no swap there
                    if (r_state != ST_READ) begin
                        w_mem_sel_nxt = ~r_mem_sel;
                    end
                end
            end
            default: begin
                w_phase_nxt   = PH_IDLE;
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = '0;
                w_mem_sel_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    assign oSTATE      = r_state;
    assign oEN         = r_en;
    assign oMEM_SEL    = r_mem_sel;
    assign oCNT        = r_cnt;
    assign oLAYER_DONE = r_layer_done;
    assign oDONE       = r_done;
    assign oBUSY       = r_busy;

endmodule
